// File: rtl/apb_initiator_pkg.sv
// Shared APB initiator definitions: FSM state encoding, default protection
// value and the byte-strobe width derivation.
package apb_initiator_pkg;

  // Transfer phases of the initiator, 2-bit encoding shared with the APB fabric
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

  // One strobe bit per data byte
  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_initiator_wait_timer.sv
// Wait-state timer for the ACCESS phase. Counts enabled cycles since the last
// clear, saturates instead of wrapping, and flags expiry when the count
// reaches TIMEOUT-1. TIMEOUT = 0 disables expiry altogether.
module apb_wait_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  // Wait counter: clear wins, otherwise count enabled cycles up to saturation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry flag, only meaningful when a finite timeout is configured
  always_comb begin
    expired = (TIMEOUT != 0) && (count == LAST);
  end

endmodule

// File: rtl/apb_initiator.sv
// APB4 requester: converts a valid/ready request/response handshake into
// APB SETUP/ACCESS transfers, one outstanding at a time, with a wait-state
// timeout guarding against hung slaves. Every output is a register.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 1024,
  localparam int STRB_W  = strb_width(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [2:0]        pprot,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_t        state, state_n;
  logic              req_ready_n;
  logic              rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic              rsp_err_n;
  logic              rsp_timeout_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [2:0]        pprot_n;
  logic              pwrite_n;
  logic [DATA_W-1:0] pwdata_n;
  logic [STRB_W-1:0] pstrb_n;
  logic              psel_n;
  logic              penable_n;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State, request latch, APB drive and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
    end else begin
      state       <= state_n;
      req_ready   <= req_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
      paddr       <= paddr_n;
      pprot       <= pprot_n;
      pwrite      <= pwrite_n;
      pwdata      <= pwdata_n;
      pstrb       <= pstrb_n;
      psel        <= psel_n;
      penable     <= penable_n;
    end
  end

  // Next state and next register values; APB inputs only matter in ACCESS
  always_comb begin
    state_n       = state;
    req_ready_n   = req_ready;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;
    paddr_n       = paddr;
    pprot_n       = pprot;
    pwrite_n      = pwrite;
    pwdata_n      = pwdata;
    pstrb_n       = pstrb;
    psel_n        = psel;
    penable_n     = penable;
    timer_clear   = 1'b0;
    timer_enable  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          paddr_n     = req_addr;
          pprot_n     = req_prot;
          pwrite_n    = req_write;
          pwdata_n    = req_wdata;
          pstrb_n     = req_write ? req_wstrb : '0;
          req_ready_n = 1'b0;
          psel_n      = 1'b1;
          penable_n   = 1'b0;
          timer_clear = 1'b1;
          state_n     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_n = 1'b1;
        state_n   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready on the expiry cycle still counts as a normal completion
        if (pready) begin
          rsp_rdata_n   = pwrite ? '0 : prdata;
          rsp_err_n     = pslverr;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          state_n       = ST_RESP;
        end else begin
          timer_enable = 1'b1;
          if (timer_expired) begin
            rsp_rdata_n   = '0;
            rsp_err_n     = 1'b1;
            rsp_timeout_n = 1'b1;
            rsp_valid_n   = 1'b1;
            psel_n        = 1'b0;
            penable_n     = 1'b0;
            state_n       = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_initiator.sv
module tb_apb_initiator;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_write = 1'b0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [STRB_W-1:0] req_wstrb = '0;
  logic [2:0]        req_prot = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              psel;
  logic              penable;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;
  logic [DATA_W-1:0] prdata = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  apb_initiator #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pprot       (pprot),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .psel        (psel),
    .penable     (penable),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset state ----
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", 32'(pstrb), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    reset = 1'b0;
    tick();

    // ---- read, zero wait states; pready raised early during SETUP ----
    req_valid = 1'b1;
    req_addr  = 32'h1000_0004;
    req_write = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    req_prot  = 3'b010;
    tick();  // N+1
    chk("rd_psel", 32'(psel), 32'h1);
    chk("rd_penable_setup", 32'(penable), 32'h0);
    chk("rd_req_ready", 32'(req_ready), 32'h0);
    chk("rd_paddr", paddr, 32'h1000_0004);
    chk("rd_pwrite", 32'(pwrite), 32'h0);
    chk("rd_pstrb", 32'(pstrb), 32'h0);
    chk("rd_pprot", 32'(pprot), 32'h2);
    req_valid = 1'b0;
    pready    = 1'b1;
    prdata    = 32'hDEAD_BEEF;
    tick();  // N+2
    chk("rd_penable_access", 32'(penable), 32'h1);
    chk("rd_psel_access", 32'(psel), 32'h1);
    chk("rd_rsp_valid_early", 32'(rsp_valid), 32'h0);
    tick();  // N+3
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    chk("rd_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("rd_psel_done", 32'(psel), 32'h0);
    chk("rd_penable_done", 32'(penable), 32'h0);
    pready    = 1'b0;
    prdata    = '0;
    rsp_ready = 1'b1;
    tick();
    chk("rd_rsp_valid_clr", 32'(rsp_valid), 32'h0);
    chk("rd_req_ready_back", 32'(req_ready), 32'h1);
    rsp_ready = 1'b0;

    // ---- write with 3 wait states ----
    req_valid = 1'b1;
    req_addr  = 32'h1000_0008;
    req_write = 1'b1;
    req_wdata = 32'h1234_5678;
    req_wstrb = 4'h3;
    req_prot  = 3'b000;
    tick();  // N+1
    req_valid = 1'b0;
    req_wdata = 32'h0;
    req_addr  = 32'h0;
    prdata    = 32'hCAFE_F00D;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      chk("wr_psel", 32'(psel), 32'h1);
      chk("wr_penable", 32'(penable), (c > 1) ? 32'h1 : 32'h0);
      chk("wr_paddr", paddr, 32'h1000_0008);
      chk("wr_pwrite", 32'(pwrite), 32'h1);
      chk("wr_pwdata", pwdata, 32'h1234_5678);
      chk("wr_pstrb", 32'(pstrb), 32'h3);
      chk("wr_rsp_valid_wait", 32'(rsp_valid), 32'h0);
      if (c == 5) pready = 1'b1;
    end
    tick();  // one cycle after pready
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("wr_psel_done", 32'(psel), 32'h0);
    pready    = 1'b0;
    prdata    = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- slave error ----
    req_valid = 1'b1;
    req_addr  = 32'h2000_0000;
    req_write = 1'b0;
    tick();  // N+1
    req_valid = 1'b0;
    tick();  // N+2
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'h55AA_55AA;
    tick();  // N+3
    chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("err_rsp_err", 32'(rsp_err), 32'h1);
    chk("err_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("err_rsp_rdata", rsp_rdata, 32'h55AA_55AA);
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- timeout after 8 ACCESS cycles ----
    req_valid = 1'b1;
    req_addr  = 32'h3000_0000;
    tick();  // N+1
    req_valid = 1'b0;
    prdata    = 32'h1111_1111;
    for (int k = 1; k <= 8; k++) begin
      tick();  // N+1+k
      chk("to_psel_wait", 32'(psel), 32'h1);
      chk("to_penable_wait", 32'(penable), 32'h1);
      chk("to_rsp_valid_wait", 32'(rsp_valid), 32'h0);
    end
    tick();  // N+10
    chk("to_psel_drop", 32'(psel), 32'h0);
    chk("to_penable_drop", 32'(penable), 32'h0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'h1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);

    // ---- response back-pressure for 10 cycles with a request waiting ----
    req_valid = 1'b1;
    req_addr  = 32'h4000_0010;
    req_write = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_err", 32'(rsp_err), 32'h1);
      chk("bp_rsp_timeout", 32'(rsp_timeout), 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_psel", 32'(psel), 32'h0);
    end
    rsp_ready = 1'b1;
    tick();  // back in IDLE
    chk("bp_rsp_valid_clr", 32'(rsp_valid), 32'h0);
    chk("bp_req_ready_back", 32'(req_ready), 32'h1);
    chk("bp_psel_idle", 32'(psel), 32'h0);
    rsp_ready = 1'b0;
    tick();  // accepted the waiting request
    chk("nx_psel", 32'(psel), 32'h1);
    chk("nx_paddr", paddr, 32'h4000_0010);
    chk("nx_req_ready", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    tick();  // ACCESS
    pready = 1'b1;
    prdata = 32'h0BAD_F00D;
    tick();
    chk("nx_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("nx_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("nx_rsp_err", 32'(rsp_err), 32'h0);
    chk("nx_rsp_timeout", 32'(rsp_timeout), 32'h0);
    pready    = 1'b0;
    prdata    = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- reset during ACCESS ----
    req_valid = 1'b1;
    req_addr  = 32'h5000_0000;
    req_write = 1'b1;
    req_wdata = 32'hA5A5_A5A5;
    req_wstrb = 4'hF;
    tick();  // SETUP
    req_valid = 1'b0;
    tick();  // ACCESS
    chk("rr_penable_pre", 32'(penable), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rr_psel", 32'(psel), 32'h0);
    chk("rr_penable", 32'(penable), 32'h0);
    chk("rr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rr_req_ready", 32'(req_ready), 32'h1);
    chk("rr_paddr", paddr, 32'h0);
    tick();
    reset  = 1'b0;
    pready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_post_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rr_post_req_ready", 32'(req_ready), 32'h1);
      chk("rr_post_psel", 32'(psel), 32'h0);
    end
    pready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
